// File: rtl/seg_display_pkg.sv
// seg_display_pkg: shared types, constants and helpers for the seven-segment
// display driver (seg_display_mux) and its binary-to-BCD converter.
//   bcd_digit_t   : one BCD nibble
//   conv_state_e  : converter FSM state (IDLE -> SHIFT -> COMMIT)
//   SEG_BLANK     : all segments off
//   SEG_DASH      : only segment g on
//   seg_decode()  : BCD digit to a..g pattern (bit0 = a), blank above 9
//   max_display() : largest value that fits in n decimal digits
package seg_display_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  function automatic logic [6:0] seg_decode(input bcd_digit_t d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // 10^n - 1, evaluated at elaboration time for the overflow threshold.
  function automatic logic [63:0] max_display(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r - 64'd1;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential shift-add-3 binary to BCD converter with
// overflow detection and a valid/ready input handshake.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   value             : unsigned binary input (VALUE_W bits)
//   value_valid       : input offered this cycle
//   ready             : converter accepts an input this cycle
//   bcd               : BCD accumulator (NUM_DIGITS nibbles, digit 0 in [3:0])
//   overflow_pending  : captured value exceeded 10^NUM_DIGITS - 1
//   state             : current FSM state (debug / commit strobe for the top)
//
// Handshake: a value is transferred on every rising clk edge where both
// value_valid and ready are high. ready is high only in IDLE and never during
// reset; value_valid while ready is low is ignored (nothing is queued).
module bin_to_bcd_seq
  import seg_display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int VALUE_W    = 14
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [VALUE_W-1:0]      value,
  input  logic                    value_valid,
  output logic                    ready,
  output logic [NUM_DIGITS*4-1:0] bcd,
  output logic                    overflow_pending,
  output conv_state_e             state
);

  localparam int          BCD_W   = NUM_DIGITS * 4;
  localparam int          CNT_W   = $clog2(VALUE_W);
  localparam logic [63:0] MAX_VAL = max_display(NUM_DIGITS);

  conv_state_e        state_q, state_d;
  logic [VALUE_W-1:0] shreg_q, shreg_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_adj;

  assign ready            = (state_q == ST_IDLE) && !reset;
  assign bcd              = bcd_q;
  assign overflow_pending = ovf_q;
  assign state            = state_q;

  // Add-3 correction: any nibble >= 5 would exceed 9 after doubling.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (value_valid && ready) begin
          shreg_d = value;
          bcd_d   = '0;
          ovf_d   = 64'(value) > MAX_VAL;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Bits leaving the top of the accumulator only matter for values
        // already flagged as overflow, so they are simply dropped.
        bcd_d   = (bcd_adj << 1) | BCD_W'(shreg_q[VALUE_W-1]);
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(VALUE_W - 1)) state_d = ST_COMMIT;
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_display_mux.sv
// seg_display_mux: multi-digit multiplexed seven-segment display driver.
// Accepts a binary value over valid/ready, converts it to BCD in
// bin_to_bcd_seq, then atomically updates the display registers and the
// overflow flag. A free-running prescaler steps the active digit.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   value        : unsigned binary value to display
//   value_valid  : value offered this cycle
//   ready        : a new value is accepted this cycle
//   seg          : segment pattern for the active digit, bit0 = a .. bit6 = g
//   dig          : one-hot active digit, dig[0] = least significant
//   overflow     : displayed value exceeded 10^NUM_DIGITS - 1 (all dashes)
// Build option: define SEG_LEADING_ZERO_BLANK_EN to blank leading zeros
// (digit 0 always shown, no blanking while overflow is set).
module seg_display_mux
  import seg_display_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int VALUE_W     = 14,
  parameter int REFRESH_DIV = 65536
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  value_valid,
  output logic                  ready,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] dig,
  output logic                  overflow
);

  localparam int BCD_W  = NUM_DIGITS * 4;
  localparam int PRE_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SCAN_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  conv_state_e       conv_state;
  logic [BCD_W-1:0]  conv_bcd;
  logic              conv_ovf;

  logic [BCD_W-1:0]  disp_q, disp_d;
  logic              ovf_q, ovf_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  bcd_digit_t        cur_digit;

  bin_to_bcd_seq #(
    .NUM_DIGITS(NUM_DIGITS),
    .VALUE_W   (VALUE_W)
  ) u_conv (
    .clk             (clk),
    .reset           (reset),
    .value           (value),
    .value_valid     (value_valid),
    .ready           (ready),
    .bcd             (conv_bcd),
    .overflow_pending(conv_ovf),
    .state           (conv_state)
  );

  // Digits and overflow load together in COMMIT so the display never shows
  // a mix of old and new value.
  always_comb begin
    disp_d = disp_q;
    ovf_d  = ovf_q;
    if (conv_state == ST_COMMIT) begin
      disp_d = conv_bcd;
      ovf_d  = conv_ovf;
    end
  end

  always_comb begin
    pre_d  = pre_q + PRE_W'(1);
    scan_d = scan_q;
    if (pre_q == PRE_W'(REFRESH_DIV - 1)) begin
      pre_d  = '0;
      scan_d = (scan_q == SCAN_W'(NUM_DIGITS - 1)) ? '0 : scan_q + SCAN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_q <= '0;
      ovf_q  <= 1'b0;
      pre_q  <= '0;
      scan_q <= '0;
    end else begin
      disp_q <= disp_d;
      ovf_q  <= ovf_d;
      pre_q  <= pre_d;
      scan_q <= scan_d;
    end
  end

  always_comb begin
    cur_digit = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_q == SCAN_W'(i)) cur_digit = disp_q[i*4 +: 4];
    end
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  cur_blank;

  // Walk down from the top digit: a digit is a leading zero while it and
  // everything above it are zero. Digit 0 is never blanked.
  always_comb begin : lz_calc
    logic upper_zero;
    upper_zero = 1'b1;
    lz_blank   = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero  = upper_zero && (disp_q[i*4 +: 4] == 4'd0);
      lz_blank[i] = upper_zero;
    end
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_q == SCAN_W'(i)) cur_blank = lz_blank[i];
    end
  end
`endif

  always_comb begin
    seg = seg_decode(cur_digit);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (cur_blank) seg = SEG_BLANK;
`endif
    if (ovf_q) seg = SEG_DASH;
  end

  assign dig      = NUM_DIGITS'(1) << scan_q;
  assign overflow = ovf_q;

endmodule
